// File: rtl/contact_collector_pkg.sv
// contact_collector_pkg: shared contact field layout, float constants and readout states
package contact_collector_pkg;
  localparam int F_CX    = 0;
  localparam int F_CY    = 1;
  localparam int F_CZ    = 2;
  localparam int F_NX    = 3;
  localparam int F_NY    = 4;
  localparam int F_NZ    = 5;
  localparam int F_DEPTH = 6;
  localparam int F_G1    = 7;
  localparam int F_G2    = 8;
  localparam int N_WORDS = 9;
  localparam logic [7:0] EXP_MASK = 8'hFF;
  localparam int SIGN_BIT = 31;
  localparam int EXP_LSB  = 23;
  typedef enum logic {IDLE, SEND} state_t;
endpackage

// File: rtl/contact_filter.sv
// contact_filter: rejects negative-nonzero or Inf/NaN penetration depths; -0.0 passes
module contact_filter
  import contact_collector_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [W-1:0] depth,
  output logic         pass
);
  assign pass = !((depth[SIGN_BIT] && depth[SIGN_BIT-1:0] != '0) || depth[EXP_LSB +: 8] == EXP_MASK);
endmodule

// File: rtl/contact_collector.sv
// contact_collector: buffers filtered contacts in a ring and streams them out word by word
module contact_collector
  import contact_collector_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int W     = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic                     in_ret,
  input  logic [N_WORDS*W-1:0]     in_contact,
  output logic                     in_ready,
  input  logic                     clear,
  output logic [W-1:0]             out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [15:0]              rejected
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [N_WORDS*W-1:0] mem [DEPTH];
  logic [N_WORDS*W-1:0] head_entry;
  logic [AW-1:0] head, tail;
  logic [3:0] idx;
  state_t state;
  logic pass, offer, acc, pop;
  contact_filter #(.W(W)) u_filter (
    .depth(in_contact[F_DEPTH*W +: W]),
    .pass (pass)
  );
  assign in_ready   = count != CW'(DEPTH);
  assign offer      = in_valid && in_ret;
  assign acc        = offer && in_ready && pass;
  assign pop        = state == SEND && out_ready && idx == 4'(F_G2);
  assign head_entry = mem[head];
  assign out_valid  = state == SEND;
  assign out_last   = out_valid && idx == 4'(F_G2);
  assign out_data   = out_valid ? head_entry[int'(idx)*W +: W] : '0;
  always_ff @(posedge clk)
    if (acc && !clear) mem[tail] <= in_contact;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      count    <= '0;
      head     <= '0;
      tail     <= '0;
      overflow <= 1'b0;
      rejected <= '0;
      state    <= IDLE;
      idx      <= '0;
    end else if (clear) begin
      count    <= '0;
      head     <= '0;
      tail     <= '0;
      overflow <= 1'b0;
      rejected <= '0;
      state    <= IDLE;
      idx      <= '0;
    end else begin
      count <= count + CW'(acc) - CW'(pop);
      if (acc) tail <= tail + 1'b1;
      if (pop) head <= head + 1'b1;
      if (offer && !in_ready) overflow <= 1'b1;
      if (offer && in_ready && !pass && rejected != 16'hFFFF) rejected <= rejected + 16'd1;
      if (state == IDLE) begin
        if (count != '0) begin
          state <= SEND;
          idx   <= '0;
        end
      end else if (out_ready) begin
        idx <= pop ? 4'd0 : idx + 4'd1;
        // a same-cycle accept keeps the stream going straight into the next entry
        if (pop && count + CW'(acc) == CW'(1)) state <= IDLE;
      end
    end
endmodule
